fft8_frame_ctrl: RTL and testbench
==================================

Name: fft8_frame_ctrl

Overview:
- Sequencer wrapped around the 8-point parallel FFT core (fft8).
- Accepts a serial stream of 16-bit samples and packs 8 of them into a frame. Issues a one-cycle start pulse to the core and waits a fixed core latency.
- Captures the 8 parallel results and streams them out serially with valid/ready handshake and end-of-frame marker.

Parameters:
- DW, 16, sample/result width; matches fft8 data_inN/data_outN width.
- FFT_LAT, 4, cycles from the fft_start cycle to the fft_dout sample point. Legal range 1..255; 0 is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_data  in  DW  input sample.
- fft_start  out  1  start pulse to fft8, one cycle wide.
- fft_din  out  8*DW  packed frame; lane i (bits [i*DW +: DW]) drives fft8 data_in(i+1).
- fft_dout  in  8*DW  packed fft8 results; lane i is data_out(i+1).
- m_valid  out  1  output result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  DW  output result.
- m_last  out  1  high with lane-7 result.
- busy  out  1  high in any state except COLLECT.

Behaviour:
- All outputs are registered.
- Reset values: s_ready=1, fft_start=0, fft_din=0, m_valid=0, m_data=0, m_last=0, busy=0. Sample counter, lane index and state are cleared (state=COLLECT).
- Reset asserted mid-frame discards partial input and output frames. No start pulse is issued, and none is pending after release.
- Handshakes are standard valid/ready: a transfer occurs on a clock edge with valid&ready both high. Holding valid without ready is legal and loses nothing.
- COLLECT: s_ready=1. The k-th accepted sample (k=0..7) is written to fft_din lane k. On the 8th accepted sample, go to LAUNCH and set s_ready=0.
- LAUNCH: fft_start=1 for exactly one cycle. Load the wait counter with FFT_LAT, then go to WAIT.
- WAIT: the counter decrements each cycle. On the edge where it reaches 0 (FFT_LAT edges after the fft_start cycle), latch fft_dout into the output buffer and go to DRAIN.
- fft_din is held stable from LAUNCH through the capture edge.
- DRAIN: m_valid=1 and m_data = output buffer lane idx, with idx starting at 0. On each m handshake idx increments. m_last=1 when idx=7.
  - Handshake with m_last: m_valid drops, idx resets to 0, state returns to COLLECT with s_ready=1.
  - m_ready held low stalls indefinitely; m_data is stable while stalled.
- Latency: 8th input handshake at edge E → fft_start high in cycle E+1 → capture at edge E+1+FFT_LAT → m_valid high from the following cycle.
- Back-to-back: with m_ready tied high, frame-to-frame period is 8 + 1 + FFT_LAT + 8 cycles (non-overlap build).
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
- Macro: FFT8_FRAME_CTRL_OVERLAP_EN.
- Defined:
  - Collection of the next frame is allowed during DRAIN (s_ready=1 in DRAIN while fewer than 8 new samples have arrived).
  - If the new frame is complete when the last result handshakes, go directly to LAUNCH in the next cycle.
  - If the new frame completes while still draining, s_ready=0 until drain finishes.
  - Steady-state period with ready tied high: max(8, 8) + 1 + FFT_LAT cycles.
- Undefined: s_ready=0 in LAUNCH/WAIT/DRAIN exactly as above.

Test Plan:
- Bench fft8 stub: registered model, FFT_LAT=4, dout lane i = din lane (7-i) + i.
- Single frame: send 128,128,128,128,0,0,0,0 with s_valid always high.
  - fft_din lanes 0..3 = 128 and lanes 4..7 = 0; fft_start high exactly 1 cycle, E+1.
  - Outputs in order are 0,1,2,3,132,133,134,135, with m_last on 135.
- Backpressure: toggle m_ready 1/0 every cycle, and hold m_ready low 20 cycles at idx=3.
  - m_data stays 3 while stalled; all 8 results are delivered in order; m_last appears once.
- Input gaps: s_valid pulsed every 3rd cycle → frame completes after the 8th pulse, and fft_start fires once.
  - Samples offered during WAIT/DRAIN are not accepted (s_ready=0, non-overlap build).
- Reset mid-operation: assert rst asynchronously after 5 samples, and again during DRAIN at idx=2.
  - All outputs immediately take reset values; no fft_start follows.
  - The next full frame of 1..8 yields outputs 8,8,8,8,8,8,8,8 (din lane (7-i) = 8-i, plus i).
- Overlap build (FFT8_FRAME_CTRL_OVERLAP_EN, m_ready=1, continuous input): two frames of 8 samples each.
  - The second fft_start occurs 8+1+FFT_LAT=13 cycles after the first.
  - No sample is lost or duplicated.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl
//   Sequencer around the 8-point parallel FFT core (fft8). Packs eight serial
//   input samples into a frame, pulses fft_start for one cycle, waits FFT_LAT
//   cycles for the core, captures the eight parallel results and streams them
//   out serially with a valid/ready handshake and an end-of-frame marker.
//   Data passes bit-exact; no arithmetic is performed on samples.
//
// Parameters
//   DW       sample/result width (matches fft8 data_inN/data_outN)
//   FFT_LAT  cycles from the fft_start cycle to the fft_dout sample point (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   s_valid    in   input sample valid
//   s_ready    out  controller can accept a sample
//   s_data     in   input sample
//   fft_start  out  one-cycle start pulse to fft8
//   fft_din    out  packed frame, lane i = bits [i*DW +: DW]
//   fft_dout   in   packed fft8 results, lane i = bits [i*DW +: DW]
//   m_valid    out  output result valid
//   m_ready    in   downstream accepts result
//   m_data     out  output result
//   m_last     out  high with the lane-7 result
//   busy       out  high in any state except COLLECT
//
// Build option
//   FFT8_FRAME_CTRL_OVERLAP_EN  when defined, the next frame may be collected
//                               while the current results drain.

module fft8_frame_ctrl #(
    parameter int DW      = 16,
    parameter int FFT_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic            fft_start,
    output logic [8*DW-1:0] fft_din,
    input  logic [8*DW-1:0] fft_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic            busy
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      lat_q, lat_d;
    logic [2:0]      idx_q, idx_d;
    logic [8*DW-1:0] din_q, din_d;
    logic [8*DW-1:0] obuf_q, obuf_d;
    logic            s_ready_q, s_ready_d;
    logic            start_q, start_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_last_q, m_last_d;
    logic            busy_q, busy_d;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
    logic            full_q, full_d;
`endif

    logic            s_hs;
    logic            m_hs;
    logic [2:0]      idx_nx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        din_d     = din_q;
        obuf_d    = obuf_q;
        s_ready_d = s_ready_q;
        start_d   = 1'b0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
        full_d    = full_q;
`endif
        s_hs   = s_valid & s_ready_q;
        m_hs   = m_valid_q & m_ready;
        idx_nx = idx_q + 3'd1;

        unique case (state_q)
            COLLECT: begin
                if (s_hs) begin
                    din_d[cnt_q*DW +: DW] = s_data;
                    cnt_d = cnt_q + 3'd1;   // wraps to 0 after lane 7
                    if (cnt_q == 3'd7) begin
                        state_d   = LAUNCH;
                        s_ready_d = 1'b0;
                        start_d   = 1'b1;   // registered, so it is high during LAUNCH
                    end
                end
            end
            LAUNCH: begin
                lat_d   = 8'(FFT_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 8'd1;
                // Counter reaches zero on this edge: the core output is due now.
                if (lat_q == 8'd1) begin
                    obuf_d    = fft_dout;
                    state_d   = DRAIN;
                    m_valid_d = 1'b1;
                    m_data_d  = fft_dout[DW-1:0];
                    m_last_d  = 1'b0;
                    idx_d     = 3'd0;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
                    s_ready_d = 1'b1;   // fft_din no longer needed; refill it
`endif
                end
            end
            DRAIN: begin
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
                if (s_hs) begin
                    din_d[cnt_q*DW +: DW] = s_data;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        full_d    = 1'b1;
                        s_ready_d = 1'b0;
                    end
                end
`endif
                if (m_hs) begin
                    if (idx_q == 3'd7) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        idx_d     = 3'd0;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
                        // full_d includes a frame completing on this same edge.
                        if (full_d) begin
                            state_d   = LAUNCH;
                            start_d   = 1'b1;
                            s_ready_d = 1'b0;
                            full_d    = 1'b0;
                        end else begin
                            state_d   = COLLECT;
                            s_ready_d = 1'b1;
                        end
`else
                        state_d   = COLLECT;
                        s_ready_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_nx;
                        m_data_d = obuf_q[idx_nx*DW +: DW];
                        m_last_d = (idx_nx == 3'd7);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            cnt_q     <= 3'd0;
            lat_q     <= 8'd0;
            idx_q     <= 3'd0;
            din_q     <= '0;
            s_ready_q <= 1'b1;
            start_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
            full_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            din_q     <= din_d;
            s_ready_q <= s_ready_d;
            start_q   <= start_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
            full_q    <= full_d;
`endif
        end
    end

    // Result buffer is only read in DRAIN after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

    assign s_ready   = s_ready_q;
    assign fft_start = start_q;
    assign fft_din   = din_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Testbench for fft8_frame_ctrl: fft8 stub (lane i = din lane (7-i) + i,
// FFT_LAT registers deep) plus a transaction-level reference model built from
// frame/queue bookkeeping and event times.
module tb_fft8_frame_ctrl;

    localparam int DW      = 16;
    localparam int FFT_LAT = 4;
`ifdef FFT8_FRAME_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            fft_start;
    logic [8*DW-1:0] fft_din;
    logic [8*DW-1:0] fft_dout;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic            busy;

    always #5 clk = ~clk;

    fft8_frame_ctrl #(.DW(DW), .FFT_LAT(FFT_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fft_start(fft_start), .fft_din(fft_din), .fft_dout(fft_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    // fft8 stub
    function automatic logic [8*DW-1:0] core_fn(input logic [8*DW-1:0] din);
        logic [8*DW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*DW +: DW] = din[(7-i)*DW +: DW] + DW'(i);
        return r;
    endfunction

    logic [8*DW-1:0] stub_p [FFT_LAT];
    always @(posedge clk) begin
        stub_p[0] <= core_fn(fft_din);
        for (int i = 1; i < FFT_LAT; i++) stub_p[i] <= stub_p[i-1];
    end
    assign fft_dout = stub_p[FFT_LAT-1];

    // Reference model state
    int              cyc, n_chk, n_bad;
    logic [DW-1:0]   src_q[$], cur_q[$], outq[$], got_q[$];
    logic [DW-1:0]   launched[8];
    int              start_q[$];
    bit              inflight;
    int              start_cyc;
    int              sv_mode, mr_mode, stall_cnt, n_start, n_last;
    logic            e_sready, e_mvalid, e_start, e_busy;
    logic [8*DW-1:0] din_at_start;

    task automatic check_val(input string tag, input logic [8*DW-1:0] got,
                             input logic [8*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [8*DW-1:0] pack_frame();
        logic [8*DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*DW +: DW] = launched[i];
        return r;
    endfunction

    task automatic launch();
        for (int i = 0; i < 8; i++) launched[i] = cur_q[i];
        cur_q.delete();
        outq.delete();
        for (int i = 0; i < 8; i++) outq.push_back(launched[7-i] + DW'(i));
        inflight  = 1'b1;
        start_cyc = cyc + 1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_s_ready"},   128'(s_ready),   128'(1));
        check_val({pfx, "_fft_start"}, 128'(fft_start), 128'(0));
        check_val({pfx, "_fft_din"},   fft_din,         128'(0));
        check_val({pfx, "_m_valid"},   128'(m_valid),   128'(0));
        check_val({pfx, "_m_data"},    128'(m_data),    128'(0));
        check_val({pfx, "_m_last"},    128'(m_last),    128'(0));
        check_val({pfx, "_busy"},      128'(busy),      128'(0));
    endtask

    // Observe one cycle and compare against the model's expectations.
    task automatic step_a();
        @(posedge clk);
        #1;
        cyc++;
        e_busy   = inflight;
        e_start  = inflight && (cyc == start_cyc);
        e_mvalid = inflight && (cyc >= start_cyc + FFT_LAT + 1);
        e_sready = OVL ? ((cur_q.size() < 8) && (!inflight || e_mvalid)) : !inflight;
        check_val("s_ready",   128'(s_ready),   128'(e_sready));
        check_val("busy",      128'(busy),      128'(e_busy));
        check_val("fft_start", 128'(fft_start), 128'(e_start));
        check_val("m_valid",   128'(m_valid),   128'(e_mvalid));
        check_val("m_last",    128'(m_last),    128'(e_mvalid && (outq.size() == 1)));
        if (e_mvalid) check_val("m_data", 128'(m_data), 128'(outq[0]));
        if (inflight && (cyc >= start_cyc) && (cyc <= start_cyc + FFT_LAT))
            check_val("fft_din_hold", fft_din, pack_frame());
        if (fft_start) begin
            n_start++;
            start_q.push_back(cyc);
            din_at_start = fft_din;
        end
    endtask

    // Drive inputs for this cycle and advance the model across the next edge.
    task automatic step_b();
        bit shs, mhs;
        case (sv_mode)
            0:       s_valid = (src_q.size() > 0);
            1:       s_valid = (src_q.size() > 0) && (cyc % 3 == 0);
            default: s_valid = (src_q.size() > 0) && ($urandom_range(0, 1) == 1);
        endcase
        s_data = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
        case (mr_mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 2 == 0);
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (e_mvalid && (outq.size() == 5) && (stall_cnt < 20)) begin
                    m_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    m_ready = (cyc % 2 == 0);
                end
            end
        endcase
        shs = s_valid && e_sready;
        mhs = m_ready && e_mvalid;
        if (mhs) begin
            got_q.push_back(m_data);
            if (m_last) n_last++;
            void'(outq.pop_front());
            if (outq.size() == 0) inflight = 1'b0;
        end
        if (shs) cur_q.push_back(src_q.pop_front());
        if ((cur_q.size() == 8) && !inflight) launch();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_reset_vals("rst");
        s_valid = 1'b0;
        m_ready = 1'b0;
        src_q.delete();
        cur_q.delete();
        outq.delete();
        inflight = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
    endtask

    // stop_kind 1: reset once stop_arg samples of a frame are held;
    // stop_kind 2: reset while result index stop_arg is presented.
    task automatic run(input int n, input int stop_kind, input int stop_arg);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            step_a();
            if (stop_kind == 1 && !inflight && cur_q.size() == stop_arg) hit = 1'b1;
            if (stop_kind == 2 && e_mvalid && outq.size() == 8 - stop_arg) hit = 1'b1;
            if (hit) begin
                async_reset();
                break;
            end
            step_b();
        end
        if (stop_kind != 0) check_val("stop_reached", 128'(hit), 128'(1));
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
    endtask

    initial begin
        logic [DW-1:0] exp_single [8];
        exp_single = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd132, 16'd133, 16'd134, 16'd135};
        n_chk = 0; n_bad = 0; cyc = 0; inflight = 1'b0; start_cyc = -100;
        sv_mode = 0; mr_mode = 0; stall_cnt = 0; n_start = 0; n_last = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #1;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single directed frame
        src_q = {16'd128, 16'd128, 16'd128, 16'd128, 16'd0, 16'd0, 16'd0, 16'd0};
        got_q.delete(); n_start = 0; n_last = 0;
        run(40, 0, 0);
        check_val("single_cnt", 128'(got_q.size()), 128'(8));
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) check_val("single_out", 128'(got_q[i]), 128'(exp_single[i]));
        check_val("single_din", din_at_start, {{4{16'h0000}}, {4{16'h0080}}});
        check_val("single_starts", 128'(n_start), 128'(1));
        check_val("single_last", 128'(n_last), 128'(1));

        // Backpressure: toggling ready, then a 20-cycle stall at idx 3
        got_q.delete(); n_last = 0; mr_mode = 1;
        load_random(8);
        run(60, 0, 0);
        check_val("toggle_cnt", 128'(got_q.size()), 128'(8));
        check_val("toggle_last", 128'(n_last), 128'(1));
        got_q.delete(); n_last = 0; mr_mode = 3; stall_cnt = 0;
        load_random(8);
        run(80, 0, 0);
        check_val("stall_len", 128'(stall_cnt), 128'(20));
        check_val("stall_cnt", 128'(got_q.size()), 128'(8));
        check_val("stall_last", 128'(n_last), 128'(1));

        // Input gaps; extra samples offered while busy
        mr_mode = 0; sv_mode = 1; n_start = 0;
        load_random(16);
        run(40, 0, 0);
        check_val("gap_one_start", 128'(n_start), 128'(1));
        run(100, 0, 0);
        check_val("gap_two_starts", 128'(n_start), 128'(2));
        check_val("gap_src_empty", 128'(src_q.size()), 128'(0));

        // Reset after 5 samples, then during DRAIN at idx 2
        sv_mode = 0; mr_mode = 0;
        load_random(8);
        run(30, 1, 5);
        n_start = 0;
        run(20, 0, 0);
        check_val("no_start_after_rst", 128'(n_start), 128'(0));
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        run(60, 2, 2);
        got_q.delete();
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        run(40, 0, 0);
        check_val("post_rst_cnt", 128'(got_q.size()), 128'(8));
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) check_val("post_rst_out", 128'(got_q[i]), 128'(8));

        // Back-to-back frames with ready high and continuous input
        start_q.delete();
        load_random(16);
        run(80, 0, 0);
        check_val("b2b_starts", 128'(start_q.size()), 128'(2));
        if (start_q.size() >= 2)
            check_val("b2b_period", 128'(start_q[1] - start_q[0]),
                      128'(OVL ? (8 + 1 + FFT_LAT) : (8 + 1 + FFT_LAT + 8)));

        // Random soak
        sv_mode = 2; mr_mode = 2; got_q.delete();
        load_random(64);
        run(1200, 0, 0);
        check_val("soak_src_empty", 128'(src_q.size()), 128'(0));
        check_val("soak_out_cnt", 128'(got_q.size()), 128'(64));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
